// File: rtl/hack_bus_sequencer_pkg.sv
// Shared state encoding and default parameter values for the Hack bus sequencer.
package hack_bus_sequencer_pkg;

  localparam int DEF_NUM_CH            = 2;
  localparam int DEF_WORD_WIDTH        = 16;
  localparam int DEF_RAM_ADDRESS_WIDTH = 14;
  localparam int DEF_NUM_GPIO          = 4;
  localparam int DEF_GPIO_BASE         = 0;
  localparam int DEF_RESET_WAIT        = 2;
  localparam int DEF_TIMEOUT           = 255;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HIGH  = 3'd3,
    ST_LOW   = 3'd4,
    ST_PAUSE = 3'd5
  } seq_state_e;

endpackage

// File: rtl/hack_bus_channel_tracker.sv
// Per-channel completion tracker: pending bit, busy-seen flag and timeout down-counter.
module hack_bus_channel_tracker
  import hack_bus_sequencer_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic abort,
  input  logic busy,
  output logic done_next,
  output logic expire
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

  logic          pending_q, pending_d;
  logic          seen_q, seen_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          released;

  // A channel finishing on its last allowed clk counts as released, not timed out.
  assign released  = pending_q && seen_q && !busy;
  assign expire    = pending_q && !released && (tmo_q == '0);
  assign done_next = !pending_q || released;

  always_comb begin
    pending_d = pending_q;
    seen_d    = seen_q;
    tmo_d     = tmo_q;
    if (abort) begin
      pending_d = 1'b0;
      seen_d    = 1'b0;
    end else if (set) begin
      pending_d = 1'b1;
      seen_d    = 1'b0;
      tmo_d     = TMO_LOAD;
    end else if (pending_q) begin
      if (released) begin
        pending_d = 1'b0;
        seen_d    = 1'b0;
      end else begin
        if (busy) seen_d = 1'b1;
        if (tmo_q != '0) tmo_d = tmo_q - TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= 1'b0;
      seen_q    <= 1'b0;
      tmo_q     <= TMO_LOAD;
    end else begin
      pending_q <= pending_d;
      seen_q    <= seen_d;
      tmo_q     <= tmo_d;
    end
  end

endmodule

// File: rtl/hack_bus_sequencer.sv
// Hack CPU clock/reset sequencer: gates each CPU cycle on SPI-SRAM channel completion
// and captures memory-mapped GPIO writes.
//
// state | meaning
// INIT  | CPU held in reset until every channel reports initialized
// ISSUE | one clk: request pulse to all channels (suppressed while CPU in reset)
// WAIT  | wait for all requested channels to finish, or time out
// HIGH  | one clk: hack_clk high, CPU commits, GPIO capture
// LOW   | one clk: hack_clk low, decide free-run or pause
// PAUSE | idle until run or a step pulse
module hack_bus_sequencer
  import hack_bus_sequencer_pkg::*;
#(
  parameter int NUM_CH            = DEF_NUM_CH,
  parameter int WORD_WIDTH        = DEF_WORD_WIDTH,
  parameter int RAM_ADDRESS_WIDTH = DEF_RAM_ADDRESS_WIDTH,
  parameter int NUM_GPIO          = DEF_NUM_GPIO,
  parameter int GPIO_BASE         = DEF_GPIO_BASE,
  parameter int RESET_WAIT        = DEF_RESET_WAIT,
  parameter int TIMEOUT           = DEF_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           run,
  input  logic                           step,
  input  logic [NUM_CH-1:0]              ch_busy,
  input  logic [NUM_CH-1:0]              ch_initialized,
  output logic [NUM_CH-1:0]              ch_request,
  input  logic [RAM_ADDRESS_WIDTH-1:0]   addressM,
  input  logic                           writeM,
  input  logic [WORD_WIDTH-1:0]          outM,
  output logic                           hack_clk,
  output logic                           hack_reset,
  output logic [NUM_GPIO*WORD_WIDTH-1:0] gpio_out,
  output logic [NUM_GPIO-1:0]            gpio_wstrobe,
  output logic [31:0]                    cycle_count,
  output logic                           timeout_err
);

  localparam int RW_W = (RESET_WAIT > 0) ? $clog2(RESET_WAIT + 1) : 1;
  localparam logic [RW_W-1:0] RW_LOAD = RW_W'(RESET_WAIT);

  seq_state_e                    state_q, state_d;
  logic [RW_W-1:0]               rw_q, rw_d;
  logic                          hack_clk_q, hack_clk_d;
  logic                          hack_reset_q, hack_reset_d;
  logic [NUM_CH-1:0]             ch_request_q, ch_request_d;
  logic [NUM_GPIO*WORD_WIDTH-1:0] gpio_q, gpio_d;
  logic [NUM_GPIO-1:0]           gpio_wstrobe_q, gpio_wstrobe_d;
  logic [31:0]                   cycle_count_q, cycle_count_d;
  logic                          timeout_err_q, timeout_err_d;

  logic [NUM_CH-1:0] ch_done_next;
  logic [NUM_CH-1:0] ch_expire;
  logic              go_init;
  logic              timeout_any;
  logic              trk_abort;
  logic [31:0]       addr_ext;
  logic [31:0]       gpio_off;
  logic              gpio_hit;
  logic              gpio_we;

  assign go_init     = (state_q != ST_INIT) && !(&ch_initialized);
  assign timeout_any = |ch_expire;
  assign trk_abort   = go_init || timeout_any;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_trk
    hack_bus_channel_tracker #(
      .TIMEOUT (TIMEOUT)
    ) u_trk (
      .clk       (clk),
      .reset     (reset),
      .set       (ch_request_q[g]),
      .abort     (trk_abort),
      .busy      (ch_busy[g]),
      .done_next (ch_done_next[g]),
      .expire    (ch_expire[g])
    );
  end

  assign addr_ext = 32'(addressM);
  assign gpio_off = addr_ext - 32'(GPIO_BASE);
  assign gpio_hit = (addr_ext >= 32'(GPIO_BASE)) && (addr_ext < 32'(GPIO_BASE + NUM_GPIO));
  assign gpio_we  = (state_q == ST_HIGH) && !hack_reset_q && writeM && gpio_hit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (&ch_initialized) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (timeout_any || (&ch_done_next)) state_d = ST_HIGH;
      ST_HIGH:  state_d = ST_LOW;
      ST_LOW:   state_d = (run || hack_reset_q) ? ST_ISSUE : ST_PAUSE;
      ST_PAUSE: if (run || step) state_d = ST_ISSUE;
      default:  state_d = ST_INIT;
    endcase
    if (go_init) state_d = ST_INIT;

    rw_d = rw_q;
    if ((state_q == ST_INIT) || go_init) begin
      rw_d = RW_LOAD;
    end else if ((state_q == ST_HIGH) && (rw_q != '0)) begin
      rw_d = rw_q - RW_W'(1);
    end

    // Outputs are registered from the next state so they align with state_q.
    hack_reset_d = (state_d == ST_INIT) || (rw_d != '0);
    hack_clk_d   = (state_d == ST_HIGH);
    ch_request_d = ((state_d == ST_ISSUE) && !hack_reset_d) ? {NUM_CH{1'b1}} : '0;

    cycle_count_d = cycle_count_q;
    if (state_q == ST_HIGH) cycle_count_d = cycle_count_q + 32'd1;

    timeout_err_d = timeout_err_q | timeout_any;

    gpio_d         = gpio_q;
    gpio_wstrobe_d = '0;
    for (int i = 0; i < NUM_GPIO; i++) begin
      if (gpio_we && (gpio_off == 32'(i))) begin
        gpio_d[i*WORD_WIDTH +: WORD_WIDTH] = outM;
        gpio_wstrobe_d[i]                 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_INIT;
      rw_q           <= RW_LOAD;
      hack_clk_q     <= 1'b0;
      hack_reset_q   <= 1'b1;
      ch_request_q   <= '0;
      gpio_q         <= '0;
      gpio_wstrobe_q <= '0;
      cycle_count_q  <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      rw_q           <= rw_d;
      hack_clk_q     <= hack_clk_d;
      hack_reset_q   <= hack_reset_d;
      ch_request_q   <= ch_request_d;
      gpio_q         <= gpio_d;
      gpio_wstrobe_q <= gpio_wstrobe_d;
      cycle_count_q  <= cycle_count_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign hack_clk     = hack_clk_q;
  assign hack_reset   = hack_reset_q;
  assign ch_request   = ch_request_q;
  assign gpio_out     = gpio_q;
  assign gpio_wstrobe = gpio_wstrobe_q;
  assign cycle_count  = cycle_count_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: doc/hack_bus_sequencer.md
HACK_BUS_SEQUENCER -- requirements
Module: hack_bus_sequencer

Interface
REQ-001 Parameter NUM_CH, default 2: number of spi_sram_encoder channels sequenced, range 1..8.
REQ-002 Parameter WORD_WIDTH, default 16: Hack data word width.
REQ-003 Parameter RAM_ADDRESS_WIDTH, default 14: addressM width.
REQ-004 Parameter NUM_GPIO, default 4; parameter GPIO_BASE, default 0: GPIO word count and base address.
REQ-005 Parameter RESET_WAIT, default 2: hack cycles held in CPU reset after all channels initialize.
REQ-006 Parameter TIMEOUT, default 255: max clk cycles a channel may stay pending.
REQ-007 clk input 1: single system clock; reset input 1: asynchronous, active-high.
REQ-008 run input 1: level, free-run enable; step input 1: one-clk pulse, launches one hack cycle while paused.
REQ-009 ch_busy input NUM_CH; ch_initialized input NUM_CH: per-channel encoder status.
REQ-010 ch_request output NUM_CH: one-clk request pulse per channel.
REQ-011 addressM input RAM_ADDRESS_WIDTH; writeM input 1; outM input WORD_WIDTH: CPU memory outputs.
REQ-012 hack_clk output 1; hack_reset output 1: CPU clock and reset.
REQ-013 gpio_out output NUM_GPIO*WORD_WIDTH: word i at bits [i*WORD_WIDTH +: WORD_WIDTH].
REQ-014 gpio_wstrobe output NUM_GPIO: one-clk pulse on update of word i.
REQ-015 cycle_count output 32: completed hack cycles; timeout_err output 1: sticky timeout flag.

Function
REQ-016 FSM states INIT, ISSUE, WAIT, HIGH, LOW, PAUSE; all transitions on posedge clk.
REQ-017 INIT: hack_clk=0, hack_reset=1, no requests; exit to ISSUE when all ch_initialized=1.
REQ-018 ISSUE, one clk: ch_request=all ones if hack_reset=0, else all zeros; per-channel pending bit set when requested; next WAIT.
REQ-019 Pending bit i clears on first clk with ch_busy[i]=0 after ch_busy[i] was seen 1; busy must rise within 1 clk of request.
REQ-020 WAIT exits to HIGH when no pending bits remain; with no requests issued, WAIT lasts exactly one clk.
REQ-021 WAIT timeout: pending beyond TIMEOUT clks -> set timeout_err, clear all pending bits, proceed to HIGH.
REQ-022 HIGH, one clk: hack_clk=1 (rising edge commits CPU state); cycle_count increments, wrapping 2^32-1 -> 0; next LOW.
REQ-023 LOW, one clk: hack_clk=0; next ISSUE if run=1 or hack_reset=1, else PAUSE.
REQ-024 PAUSE: hack_clk=0; to ISSUE when run=1 or step=1; step while not in PAUSE is ignored.
REQ-025 Reset-wait counter loads RESET_WAIT in INIT, decrements each HIGH while nonzero; hack_reset = (counter!=0) or (state==INIT).
REQ-026 GPIO: in HIGH with hack_reset=0, writeM=1, GPIO_BASE <= addressM < GPIO_BASE+NUM_GPIO -> word (addressM-GPIO_BASE) <= outM, matching gpio_wstrobe bit pulses same clk.
REQ-027 Writes outside GPIO window, or while hack_reset=1, leave gpio_out unchanged.
REQ-028 Any ch_initialized bit dropping in any non-INIT state -> INIT next clk: pending cleared, requests 0, counter reloaded; gpio_out, cycle_count, timeout_err kept.
REQ-029 Initialized-drop and timeout in same clk: initialized-drop wins; timeout_err still set.
REQ-030 RESET_WAIT=0: hack_reset deasserts on first exit from INIT.

Reset
REQ-031 reset=1 asynchronously: state INIT, hack_clk=0, hack_reset=1, ch_request=0, pending=0, gpio_out=0, gpio_wstrobe=0, cycle_count=0, timeout_err=0, counter=RESET_WAIT.
REQ-032 Reset asserted mid-transaction abandons the transaction; no request pulse emitted during or on the clk after release.

Structure
REQ-033 State encoding and default parameter values live in the shared params include.
REQ-034 One sub-module hack_bus_channel_tracker (one pending bit, busy-seen flag, timeout counter per channel), instantiated NUM_CH times via generate.

Verification
REQ-035 Init: NUM_CH=2, ch_initialized 0->11 at clk 10 -> hack_reset low after exactly 2 HIGH states; no ch_request pulses before that.
REQ-036 Skewed busy: ch0 busy 3 clks, ch1 busy 7 clks -> HIGH entered exactly 1 clk after ch1 busy falls.
REQ-037 GPIO: writeM=1, addressM=2, outM=16'hBEEF in HIGH -> gpio word 2=16'hBEEF, gpio_wstrobe=4'b0100 one clk; addressM=4 -> no change.
REQ-038 Timeout: TIMEOUT=8, ch1 busy held high -> timeout_err=1 after 8 pending clks, cycle completes, cycle_count advances by 1.
REQ-039 Step: run=0, in PAUSE, three step pulses -> cycle_count +3, exactly 3 hack_clk pulses, returns to PAUSE.
REQ-040 Mid-run: ch_initialized[0] drops in WAIT -> INIT next clk, hack_reset=1, gpio_out retained; async reset mid-WAIT -> all REQ-031 values immediately.
